// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    MULDIV_WAIT,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [1:0] FWD_REGFILE   = 2'b00;
  localparam logic [1:0] FWD_WRITEBACK = 2'b01;
  localparam logic [1:0] FWD_MEMORY    = 2'b10;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // Register 0 is hardwired, so it can never produce a dependency.
  function automatic logic reg_match(input logic en, input logic [4:0] dst,
                                     input logic [4:0] src);
    return en && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational operand-forwarding selects for the execute and decode stages.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] Rs_decode,
  input  logic [4:0] Rt_decode,
  input  logic [4:0] Rs_execute,
  input  logic [4:0] Rt_execute,
  input  logic [4:0] write_register_memory,
  input  logic [4:0] write_register_writeback,
  input  logic       register_write_memory,
  input  logic       register_write_writeback,
  output logic [1:0] forward_A_execute,
  output logic [1:0] forward_B_execute,
  output logic       forward_A_decode,
  output logic       forward_B_decode
);

  // Memory stage holds the younger result, so it wins over writeback.
  function automatic logic [1:0] select(input logic [4:0] src);
    if (reg_match(register_write_memory, write_register_memory, src))
      return FWD_MEMORY;
    else if (reg_match(register_write_writeback, write_register_writeback, src))
      return FWD_WRITEBACK;
    else
      return FWD_REGFILE;
  endfunction

  always_comb begin
    forward_A_execute = select(Rs_execute);
    forward_B_execute = select(Rt_execute);
    forward_A_decode  = reg_match(register_write_memory, write_register_memory, Rs_decode);
    forward_B_decode  = reg_match(register_write_memory, write_register_memory, Rt_decode);
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forward control with HI/LO occupancy and HALT drain.
// Optional HAZARD_STATS_EN adds a saturating stall_count output.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_decode,
  input  logic [4:0] Rt_decode,
  input  logic [4:0] Rs_execute,
  input  logic [4:0] Rt_execute,
  input  logic [4:0] write_register_execute,
  input  logic [4:0] write_register_memory,
  input  logic [4:0] write_register_writeback,
  input  logic       register_write_execute,
  input  logic       register_write_memory,
  input  logic       register_write_writeback,
  input  logic       memory_to_register_execute,
  input  logic       memory_to_register_memory,
  input  logic       branch_decode,
  input  logic       using_HI_LO_decode,
  input  logic       HI_register_write_execute,
  input  logic       LO_register_write_execute,
  input  logic [5:0] op_execute,
  input  logic [5:0] ALU_function_execute,
  input  logic       HALT_execute,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       clear_decode_execute,
  output logic       clear_fetch_decode,
  output logic [1:0] forward_A_execute,
  output logic [1:0] forward_B_execute,
  output logic       forward_A_decode,
  output logic       forward_B_decode,
  output logic       muldiv_busy,
  output logic       halted
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int MAX_LAT_MD = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int MAX_LAT    = (MAX_LAT_MD > DRAIN_CYCLES) ? MAX_LAT_MD : DRAIN_CYCLES;
  localparam int CW         = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] MULT_LOAD  = CW'(MULT_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LOAD   = CW'(DIV_LATENCY - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] md_count;
  logic [CW-1:0] drain_count;
  logic [CW-1:0] md_next;
  logic [CW-1:0] drain_load;
  logic [CW-1:0] start_load;
  logic          is_mult, is_div, muldiv_start;
  logic          lw_stall, br_stall, hilo_stall, hazard, hold;

  forwarding_unit u_forwarding_unit (
    .Rs_decode               (Rs_decode),
    .Rt_decode               (Rt_decode),
    .Rs_execute              (Rs_execute),
    .Rt_execute              (Rt_execute),
    .write_register_memory   (write_register_memory),
    .write_register_writeback(write_register_writeback),
    .register_write_memory   (register_write_memory),
    .register_write_writeback(register_write_writeback),
    .forward_A_execute       (forward_A_execute),
    .forward_B_execute       (forward_B_execute),
    .forward_A_decode        (forward_A_decode),
    .forward_B_decode        (forward_B_decode)
  );

  always_comb begin
    is_mult      = (ALU_function_execute == FUNCT_MULT) || (ALU_function_execute == FUNCT_MULTU);
    is_div       = (ALU_function_execute == FUNCT_DIV) || (ALU_function_execute == FUNCT_DIVU);
    muldiv_start = (HI_register_write_execute || LO_register_write_execute) &&
                   (op_execute == 6'd0) && (is_mult || is_div);
    start_load   = is_div ? DIV_LOAD : MULT_LOAD;
    // md_count always holds the remaining HI/LO occupancy, in WAIT and in DRAIN.
    drain_load   = (md_count > DRAIN_LOAD) ? md_count : DRAIN_LOAD;
    md_next      = (md_count != '0) ? md_count - CW'(1) : '0;

    lw_stall   = memory_to_register_execute &&
                 (reg_match(1'b1, write_register_execute, Rs_decode) ||
                  reg_match(1'b1, write_register_execute, Rt_decode));
    br_stall   = branch_decode &&
                 (reg_match(register_write_execute, write_register_execute, Rs_decode) ||
                  reg_match(register_write_execute, write_register_execute, Rt_decode) ||
                  reg_match(memory_to_register_memory, write_register_memory, Rs_decode) ||
                  reg_match(memory_to_register_memory, write_register_memory, Rt_decode));
    hilo_stall = using_HI_LO_decode && muldiv_busy;
    hazard     = lw_stall || br_stall || hilo_stall;
    hold       = (state == DRAIN) || (state == HALTED);

    stall_fetch          = hold || hazard;
    stall_decode         = hold || hazard;
    clear_decode_execute = hold || hazard;
    clear_fetch_decode   = hold;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      md_count    <= '0;
      drain_count <= '0;
      muldiv_busy <= 1'b0;
      halted      <= 1'b0;
    end else if (state != HALTED && HALT_execute) begin
      state       <= DRAIN;
      drain_count <= drain_load;
      muldiv_busy <= (md_count != '0);
    end else begin
      case (state)
        RUN, MULDIV_WAIT: begin
          if (muldiv_start) begin
            state       <= MULDIV_WAIT;
            md_count    <= start_load;
            muldiv_busy <= 1'b1;
          end else if (state == MULDIV_WAIT) begin
            if (md_count == '0) begin
              state       <= RUN;
              muldiv_busy <= 1'b0;
            end else begin
              md_count <= md_count - CW'(1);
            end
          end
        end
        DRAIN: begin
          md_count <= md_next;
          if (drain_count == '0) begin
            state       <= HALTED;
            md_count    <= '0;
            muldiv_busy <= 1'b0;
            halted      <= 1'b1;
          end else begin
            drain_count <= drain_count - CW'(1);
            muldiv_busy <= (md_next != '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset)
      stall_count <= '0;
    else if (!hold && hazard && stall_count != '1)
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule
